// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between fetch and data load/store
// Data wins by default; fetch is forced through after STARVE_LIMIT lost cycles.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_stallreq_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_stallreq_o,
  output logic                    ram_ce_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);
  localparam int LAST = RD_LATENCY - 1;

  logic [CNT_WIDTH-1:0]  starve_cnt;
  logic [RD_LATENCY-1:0] tag_valid;
  logic [RD_LATENCY-1:0] tag_data;
  logic [RD_LATENCY-1:0] tag_squash;
  logic                  force_if;
  logic                  if_win;
  logic                  d_win;
  logic                  rd_grant;

  // Grants are gated by reset so every output reads 0 while rst_i is low.
  assign force_if = if_req_i & (starve_cnt == CNT_MAX);
  assign if_win   = rst_i & (force_if | (if_req_i & ~d_req_i));
  assign d_win    = rst_i & d_req_i & ~if_win;
  assign rd_grant = if_win | (d_win & ~d_we_i);

  assign if_gnt_o      = if_win;
  assign d_gnt_o       = d_win;
  assign if_stallreq_o = rst_i & if_req_i & ~if_win;
  assign d_stallreq_o  = rst_i & d_req_i & ~d_win;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= '0;
    end else if (if_req_i & ~if_win) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_WIDTH'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Tag stage i holds the read issued i+1 edges ago; tag_data=1 marks a data-port owner.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tag_valid  <= '0;
      tag_data   <= '0;
      tag_squash <= '0;
    end else begin
      tag_valid[0]  <= rd_grant;
      tag_data[0]   <= d_win;
      tag_squash[0] <= if_win & flush_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_valid[i]  <= tag_valid[i-1];
        tag_data[i]   <= tag_data[i-1];
        tag_squash[i] <= tag_squash[i-1] | (flush_i & ~tag_data[i-1]);
      end
    end
  end

  // A flush in the return cycle also kills the fetch being returned right now.
  assign d_rvalid_o  = tag_valid[LAST] & tag_data[LAST];
  assign if_rvalid_o = tag_valid[LAST] & ~tag_data[LAST] & ~tag_squash[LAST] & ~flush_i;
  assign d_rdata_o   = d_rvalid_o  ? ram_rdata_i : '0;
  assign if_rdata_o  = if_rvalid_o ? ram_rdata_i : '0;

  always_comb begin
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (if_win) begin
      ram_ce_o   = 1'b1;
      ram_be_o   = {BE_WIDTH{1'b1}};
      ram_addr_o = if_addr_i;
    end else if (d_win) begin
      ram_ce_o    = 1'b1;
      ram_we_o    = d_we_i;
      ram_be_o    = d_be_i;
      ram_addr_o  = d_addr_i;
      ram_wdata_o = d_wdata_i;
    end
  end

endmodule
